// File: rtl/up_down_counter_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// up_down_counter_sweep_ctrl
//
// Sequencer for an external up_down_counter (ports mode, clk, rst, count).
// On an accepted sweep command (lo, hi, n_sweeps) it releases the counter
// from reset so count ramps 0 -> hi, then oscillates hi -> lo -> hi until
// n_sweeps hi->lo sweeps have completed. While idle the counter is held in
// reset (count = 0).
//
// Optional feature (macro UDC_SWEEP_CHECK_EN):
//   A shadow model predicts the counter value every cycle while busy. Any
//   difference sets the sticky mismatch flag and aborts the run. Without
//   the macro the model is absent and mismatch is tied to 0.
//
// Parameters
//   WIDTH      counter width, must match the counter's count port
//   SWEEP_W    width of n_sweeps and sweep_cnt
//
// Ports
//   clk        in   rising-edge clock, shared with the counter
//   rst        in   synchronous active-high reset
//   start      in   command strobe, sampled only in IDLE
//   lo         in   lower turn point, sampled with start
//   hi         in   upper turn point, sampled with start
//   n_sweeps   in   number of hi->lo sweeps, sampled with start
//   abort      in   terminate the current run (wins over start in IDLE)
//   count      in   counter output, fed back
//   cnt_mode   out  counter mode: 0 = up, 1 = down (registered)
//   cnt_rst    out  counter reset (registered)
//   busy       out  high while a run is active
//   done       out  1-cycle pulse when a run completes normally
//   cmd_err    out  1-cycle pulse when a start is rejected
//   sweep_cnt  out  completed sweeps in the current or last run
//   mismatch   out  sticky count-check error
// ---------------------------------------------------------------------------
module up_down_counter_sweep_ctrl #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned SWEEP_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [SWEEP_W-1:0] n_sweeps,
  input  logic               abort,
  input  logic [WIDTH-1:0]   count,
  output logic               cnt_mode,
  output logic               cnt_rst,
  output logic               busy,
  output logic               done,
  output logic               cmd_err,
  output logic [SWEEP_W-1:0] sweep_cnt,
  output logic               mismatch
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RISE = 2'd1,
    ST_FALL = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [SWEEP_W-1:0] n_q, n_d;
  logic [SWEEP_W-1:0] sweep_q, sweep_d;
  logic               mode_q, mode_d;
  logic               crst_q, crst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               cmd_ok;
  logic               at_peak_turn;
  logic               at_trough_turn;
  logic [SWEEP_W-1:0] sweep_inc;
  logic               check_fail;

`ifdef UDC_SWEEP_CHECK_EN
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic               mm_q, mm_d;
`endif

  // Bounds test done one bit wider so lo+2 cannot wrap for lo near max.
  assign cmd_ok = (({1'b0, lo} + (WIDTH+1)'(2)) <= {1'b0, hi}) &&
                  (n_sweeps != '0);

  // The counter registers mode, so turns are requested one step early:
  // seeing hi-1 makes the next-but-one step go down, peaking at exactly hi;
  // seeing lo+1 while falling makes the counter trough at exactly lo.
  assign at_peak_turn   = (count == (hi_q - WIDTH'(1)));
  assign at_trough_turn = (count == (lo_q + WIDTH'(1)));
  assign sweep_inc      = sweep_q + SWEEP_W'(1);

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    n_d     = n_q;
    sweep_d = sweep_q;
    mode_d  = mode_q;
    crst_d  = crst_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

`ifdef UDC_SWEEP_CHECK_EN
    mm_d       = mm_q;
    // Shadow counter: mirrors what the external counter does with the
    // mode/rst values it is sampling this edge.
    if (crst_q) begin
      exp_d = '0;
    end else if (mode_q) begin
      exp_d = exp_q - WIDTH'(1);
    end else begin
      exp_d = exp_q + WIDTH'(1);
    end
    check_fail = busy_q && (count != exp_q);
`else
    check_fail = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        // abort in IDLE suppresses both a run and an error pulse
        if (!abort && start) begin
          if (cmd_ok) begin
            lo_d    = lo;
            hi_d    = hi;
            n_d     = n_sweeps;
            sweep_d = '0;
            mode_d  = 1'b0;
            crst_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = ST_RISE;
`ifdef UDC_SWEEP_CHECK_EN
            mm_d    = 1'b0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_RISE, ST_FALL: begin
        if (abort || check_fail) begin
          state_d = ST_IDLE;
          crst_d  = 1'b1;
          mode_d  = 1'b0;
          busy_d  = 1'b0;
`ifdef UDC_SWEEP_CHECK_EN
          if (check_fail) begin
            mm_d = 1'b1;
          end
`endif
        end else if (state_q == ST_RISE) begin
          // Only the peak is watched here, so the initial ramp from 0
          // passes lo+1 without effect.
          if (at_peak_turn) begin
            mode_d  = 1'b1;
            state_d = ST_FALL;
          end
        end else begin
          if (at_trough_turn) begin
            sweep_d = sweep_inc;
            if (sweep_inc == n_q) begin
              state_d = ST_IDLE;
              crst_d  = 1'b1;
              mode_d  = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              mode_d  = 1'b0;
              state_d = ST_RISE;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        crst_d  = 1'b1;
        mode_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      n_q     <= '0;
      sweep_q <= '0;
      mode_q  <= 1'b0;
      crst_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef UDC_SWEEP_CHECK_EN
      exp_q   <= '0;
      mm_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      sweep_q <= sweep_d;
      mode_q  <= mode_d;
      crst_q  <= crst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef UDC_SWEEP_CHECK_EN
      exp_q   <= exp_d;
      mm_q    <= mm_d;
`endif
    end
  end

  assign cnt_mode  = mode_q;
  assign cnt_rst   = crst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_err   = err_q;
  assign sweep_cnt = sweep_q;

`ifdef UDC_SWEEP_CHECK_EN
  assign mismatch  = mm_q;
`else
  assign mismatch  = 1'b0;
`endif

endmodule

// File: tb/tb_up_down_counter_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_up_down_counter_sweep_ctrl
//
// Drives the sweep controller together with a behavioural up/down counter
// and compares every cycle against count/sweep sequences built directly
// from the sweep rules (ramp 0..hi, then hi-1..lo and lo+1..hi per sweep).
// ---------------------------------------------------------------------------
module tb_up_down_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] lo = '0;
  logic [3:0] hi = '0;
  logic [7:0] n_sweeps = '0;
  logic [3:0] count;
  logic [3:0] ctr_q = '0;
  logic       force_en = 1'b0;
  logic [3:0] force_val = '0;

  logic       cnt_mode, cnt_rst, busy, done, cmd_err, mismatch;
  logic [7:0] sweep_cnt;

  int total = 0;
  int bad   = 0;
  int exp_mm = 0;
  int last_sweep = 0;

  up_down_counter_sweep_ctrl #(.WIDTH(4), .SWEEP_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .lo        (lo),
    .hi        (hi),
    .n_sweeps  (n_sweeps),
    .abort     (abort),
    .count     (count),
    .cnt_mode  (cnt_mode),
    .cnt_rst   (cnt_rst),
    .busy      (busy),
    .done      (done),
    .cmd_err   (cmd_err),
    .sweep_cnt (sweep_cnt),
    .mismatch  (mismatch)
  );

  always #5 clk = ~clk;

  // External up_down_counter
  always @(posedge clk) begin
    if (cnt_rst) ctr_q <= '0;
    else if (cnt_mode) ctr_q <= ctr_q - 4'd1;
    else ctr_q <= ctr_q + 4'd1;
  end

  // Fault injection point on the feedback path
  assign count = force_en ? force_val : ctr_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_outs(input string tag, input int exp_sw);
    chk({tag, ".busy"},     32'(busy),      0);
    chk({tag, ".done"},     32'(done),      0);
    chk({tag, ".cmd_err"},  32'(cmd_err),   0);
    chk({tag, ".cnt_rst"},  32'(cnt_rst),   1);
    chk({tag, ".count"},    32'(count),     0);
    chk({tag, ".sweep"},    32'(sweep_cnt), exp_sw);
    chk({tag, ".mismatch"}, 32'(mismatch),  exp_mm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; abort = 1'b0; force_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_mm = 0;
    last_sweep = 0;
    chk("reset.cnt_mode", 32'(cnt_mode), 0);
    idle_outs("reset", 0);
    rst = 1'b0;
  endtask

  // Command presented in IDLE that must not start a run.
  task automatic cmd_idle(input int l, input int h, input int n, input bit ab);
    bit ok;
    ok = (l + 2 <= h) && (n != 0);
    start = 1'b1; lo = 4'(l); hi = 4'(h); n_sweeps = 8'(n); abort = ab;
    @(posedge clk); @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("idle_cmd.cmd_err", 32'(cmd_err), (!ab && !ok) ? 1 : 0);
    chk("idle_cmd.busy",    32'(busy),    0);
    chk("idle_cmd.cnt_rst", 32'(cnt_rst), 1);
    chk("idle_cmd.count",   32'(count),   0);
    chk("idle_cmd.sweep",   32'(sweep_cnt), last_sweep);
    chk("idle_cmd.mismatch",32'(mismatch), exp_mm);
    @(posedge clk); @(negedge clk);
    chk("idle_cmd.err_pulse", 32'(cmd_err), 0);
    chk("idle_cmd.busy2",     32'(busy),    0);
  endtask

  // Accepted run. ab_at / flt_at / rs_at: edge index (after E0) at which
  // abort / a forced count / rst is sampled; -1 = none.
  task automatic run(input int l, input int h, input int n, input int ab_at,
                     input int flt_at, input int rs_at, input bit noisy);
    int seq[$];
    int sw[$];
    int len;
    int term_sw;
    bit fin;
    for (int v = 0; v <= h; v++) begin seq.push_back(v); sw.push_back(0); end
    for (int s = 1; s <= n; s++) begin
      for (int v = h - 1; v >= l; v--) begin
        seq.push_back(v);
        sw.push_back(v == l ? s : s - 1);
      end
      if (s < n) begin
        for (int v = l + 1; v <= h; v++) begin seq.push_back(v); sw.push_back(s); end
      end
    end
    len = seq.size();
    term_sw = n;
    fin = 1'b0;

    start = 1'b1; lo = 4'(l); hi = 4'(h); n_sweeps = 8'(n); abort = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    exp_mm = 0;

    for (int k = 0; k < len && !fin; k++) begin
      if (k == rs_at) begin
        fin = 1'b1; term_sw = 0; exp_mm = 0;
        chk("rst.cnt_mode", 32'(cnt_mode), 0);
        chk("rst.cnt_rst",  32'(cnt_rst),  1);
        chk("rst.busy",     32'(busy),     0);
        chk("rst.done",     32'(done),     0);
        chk("rst.cmd_err",  32'(cmd_err),  0);
        chk("rst.sweep",    32'(sweep_cnt), 0);
        chk("rst.mismatch", 32'(mismatch), 0);
        chk("rst.count",    32'(count),    seq[k]);
      end else if (k == ab_at || k == flt_at) begin
        fin = 1'b1; term_sw = sw[k-1];
        if (k == flt_at) exp_mm = 1;
        chk("stop.busy",     32'(busy),      0);
        chk("stop.done",     32'(done),      0);
        chk("stop.cnt_rst",  32'(cnt_rst),   1);
        chk("stop.sweep",    32'(sweep_cnt), sw[k-1]);
        chk("stop.count",    32'(count),     seq[k]);
        chk("stop.mismatch", 32'(mismatch),  exp_mm);
      end else begin
        if (k == len - 1) fin = 1'b1;
        chk("run.count",    32'(count),     seq[k]);
        chk("run.sweep",    32'(sweep_cnt), sw[k]);
        chk("run.busy",     32'(busy),      (k < len - 1) ? 1 : 0);
        chk("run.done",     32'(done),      (k == len - 1) ? 1 : 0);
        chk("run.cnt_rst",  32'(cnt_rst),   (k == len - 1) ? 1 : 0);
        chk("run.cmd_err",  32'(cmd_err),   0);
        chk("run.mismatch", 32'(mismatch),  0);
        if (k < len - 1) chk("run.cnt_mode", 32'(cnt_mode), (seq[k+1] < seq[k]) ? 1 : 0);
      end
      start = 1'b0; abort = 1'b0; force_en = 1'b0; rst = 1'b0;
      if (!fin) begin
        abort = (k + 1 == ab_at);
        rst   = (k + 1 == rs_at);
        if (k + 1 == flt_at) begin
          force_en  = 1'b1;
          force_val = 4'((seq[k] + 1 + int'($urandom_range(0, 13))) % 16);
        end
        // Start while busy must be ignored whatever its parameters.
        if (noisy && $urandom_range(0, 3) == 0) begin
          start = 1'b1; lo = 4'($urandom); hi = 4'($urandom); n_sweeps = 8'($urandom);
        end
        @(posedge clk); @(negedge clk);
      end
    end
    @(posedge clk); @(negedge clk);
    last_sweep = term_sw;
    idle_outs("after", term_sw);
  endtask

  initial begin
    int h, l, n, len, sel, lx, hx;
    do_reset();

    run(2, 5, 2, -1, -1, -1, 1'b0);   // reference sequence 0..5,4,3,2,3,4,5,4,3,2
    cmd_idle(3, 4, 2, 1'b0);          // lo+2 > hi
    cmd_idle(2, 5, 0, 1'b0);          // n_sweeps == 0
    cmd_idle(1, 10, 3, 1'b1);         // abort beats valid start
    run(0, 15, 1, -1, -1, -1, 1'b0);  // full range, no wrap
    run(2, 5, 2, 4, -1, -1, 1'b1);    // abort after count=3
    run(2, 6, 2, -1, -1, 9, 1'b0);    // rst while falling
    run(0, 2, 3, -1, -1, -1, 1'b1);   // tightest bounds
    run(13, 15, 2, -1, -1, -1, 1'b1); // top of range
`ifdef UDC_SWEEP_CHECK_EN
    run(1, 6, 2, -1, 5, -1, 1'b0);    // corrupted feedback
    cmd_idle(15, 1, 1, 1'b0);         // mismatch stays sticky
    run(1, 6, 1, -1, -1, -1, 1'b0);   // accepted start clears it
`endif

    for (int i = 0; i < 40; i++) begin
      h = int'($urandom_range(2, 15));
      l = int'($urandom_range(0, h - 2));
      n = int'($urandom_range(1, 3));
      len = h + 1 + (2 * n - 1) * (h - l);
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: cmd_idle(l, h, 0, 1'b0);
        1: begin
          lx = int'($urandom_range(0, 15));
          hx = int'($urandom_range(0, (lx + 1 > 15) ? 15 : lx + 1));
          cmd_idle(lx, hx, n, 1'b0);
        end
        2: cmd_idle(l, h, n, 1'b1);
        3, 4: run(l, h, n, int'($urandom_range(1, len - 1)), -1, -1, 1'b1);
        5: begin
          run(l, h, n, -1, -1, int'($urandom_range(1, len - 1)), 1'b1);
        end
`ifdef UDC_SWEEP_CHECK_EN
        6: run(l, h, n, -1, int'($urandom_range(1, len - 1)), -1, 1'b1);
`endif
        default: run(l, h, n, -1, -1, -1, 1'b1);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
